// File: rtl/snpu_policy_deck.sv
// Policy-card deck engine: draw stack, implicit discard pile and board tallies.
// It serves deck ops over a valid/ready port and shuffles by LFSR rejection sampling.
module snpu_policy_deck #(
  parameter int unsigned N_CARDS   = 17,
  parameter int unsigned N_LIB     = 6,
  parameter logic [7:0]  LFSR_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_arg,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [N_CARDS-1:0] DeckInit = N_CARDS'((64'd1 << N_LIB) - 64'd1);
  localparam logic [4:0] NCardsW = 5'(N_CARDS);
  localparam logic [4:0] NLibW   = 5'(N_LIB);

  localparam logic [2:0] OpNop     = 3'd0;
  localparam logic [2:0] OpReset   = 3'd1;
  localparam logic [2:0] OpPeek    = 3'd2;
  localparam logic [2:0] OpDiscard = 3'd3;
  localparam logic [2:0] OpPlay    = 3'd4;
  localparam logic [2:0] OpShuffle = 3'd5;
  localparam logic [2:0] OpStatus  = 3'd6;

  typedef enum logic [1:0] {StIdle, StShuf, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_CARDS-1:0] stack_q, stack_d;
  logic [4:0]         stack_n_q, stack_n_d;
  logic [4:0]         discard_n_q, discard_n_d;
  logic [4:0]         board_lib_q, board_lib_d;
  logic [4:0]         board_fas_q, board_fas_d;
  logic [4:0]         rem_q, rem_d;
  logic [4:0]         lib_rem_q, lib_rem_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         rsp_data_q, rsp_data_d;

  logic               accept;
  logic               start_shuf;
  logic [4:0]         shuf_rem;
  logic [4:0]         rnd;
  logic               card_ok;
  logic               card_val;
  logic [N_CARDS-1:0] keep_mask;
  logic [N_CARDS-1:0] stack_removed;
  logic [4:0]         play_lib;
  logic [4:0]         play_fas;
  logic               place;
  logic               place_bit;

  assign accept     = cmd_valid & cmd_ready;
  assign start_shuf = accept && ((cmd_op == OpReset) || (cmd_op == OpShuffle));
  assign shuf_rem   = (cmd_op == OpReset) ? NCardsW : stack_n_q + discard_n_q;
  assign rnd        = lfsr_q[4:0];
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Only the top three cards are addressable.
  assign card_ok  = (cmd_arg != 2'd3) && ({3'b000, cmd_arg} < stack_n_q);
  assign card_val = stack_q[cmd_arg];

  // Bits below k stay put, bits above k slide down one; the vacated top bit fills with 0.
  assign keep_mask     = (N_CARDS'(1) << cmd_arg) - N_CARDS'(1);
  assign stack_removed = (stack_q & keep_mask) | ((stack_q >> 1) & ~keep_mask);
  assign play_lib      = board_lib_q + {4'b0000, card_val};
  assign play_fas      = board_fas_q + {4'b0000, ~card_val};

  // One rejection-sampling step: forced placements when only one card kind remains.
  always_comb begin
    place     = 1'b0;
    place_bit = 1'b0;
    if (state_q == StShuf) begin
      if (lib_rem_q == 5'd0) begin
        place = 1'b1;
      end else if (lib_rem_q == rem_q) begin
        place     = 1'b1;
        place_bit = 1'b1;
      end else if (rnd < rem_q) begin
        place     = 1'b1;
        place_bit = (rnd < lib_rem_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_shuf) state_d = (shuf_rem == 5'd0) ? StDone : StShuf;
      end
      StShuf: begin
        if (place && (rem_q == 5'd1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    rsp_valid = rsp_valid_q | (state_q == StDone);
    rsp_err   = rsp_err_q;
    rsp_data  = (state_q == StDone) ? {3'b000, stack_n_q} : rsp_data_q;
  end

  // Datapath: single-cycle ops, shuffle setup and per-cycle card placement.
  always_comb begin
    stack_d     = stack_q;
    stack_n_d   = stack_n_q;
    discard_n_d = discard_n_q;
    board_lib_d = board_lib_q;
    board_fas_d = board_fas_q;
    rem_d       = rem_q;
    lib_rem_d   = lib_rem_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = {3'b000, stack_n_q};
      unique case (cmd_op)
        OpNop: ;
        OpReset, OpShuffle: begin
          // Response comes from DONE; stack_n doubles as the placement index meanwhile.
          rsp_valid_d = 1'b0;
          rem_d       = shuf_rem;
          discard_n_d = 5'd0;
          stack_d     = '0;
          stack_n_d   = 5'd0;
          if (cmd_op == OpReset) begin
            board_lib_d = 5'd0;
            board_fas_d = 5'd0;
            lib_rem_d   = NLibW;
          end else begin
            lib_rem_d = NLibW - board_lib_q;
          end
        end
        OpPeek: begin
          if (stack_n_q < 5'd3) rsp_err_d = 1'b1;
          else                  rsp_data_d = {stack_n_q, stack_q[2:0]};
        end
        OpDiscard, OpPlay: begin
          if (!card_ok) begin
            rsp_err_d = 1'b1;
          end else begin
            stack_d   = stack_removed;
            stack_n_d = stack_n_q - 5'd1;
            if (cmd_op == OpDiscard) begin
              discard_n_d = discard_n_q + 5'd1;
              rsp_data_d  = {3'b000, stack_n_q - 5'd1};
            end else begin
              board_lib_d = play_lib;
              board_fas_d = play_fas;
              rsp_data_d  = {1'b0, play_fas[2:0], 1'b0, play_lib[2:0]};
            end
          end
        end
        OpStatus: rsp_data_d = {3'b000, discard_n_q};
        default:  rsp_err_d = 1'b1;
      endcase
    end

    if (place) begin
      stack_d[stack_n_q] = place_bit;
      stack_n_d          = stack_n_q + 5'd1;
      rem_d              = rem_q - 5'd1;
      lib_rem_d          = lib_rem_q - {4'b0000, place_bit};
    end

    if (state_q == StDone) rsp_data_d = {3'b000, stack_n_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q     <= DeckInit;
      stack_n_q   <= NCardsW;
      discard_n_q <= 5'd0;
      board_lib_q <= 5'd0;
      board_fas_q <= 5'd0;
      rem_q       <= 5'd0;
      lib_rem_q   <= 5'd0;
      lfsr_q      <= LFSR_SEED;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      stack_q     <= stack_d;
      stack_n_q   <= stack_n_d;
      discard_n_q <= discard_n_d;
      board_lib_q <= board_lib_d;
      board_fas_q <= board_fas_d;
      rem_q       <= rem_d;
      lib_rem_q   <= lib_rem_d;
      lfsr_q      <= lfsr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Deck conservation; discard liberals are implicit so only an upper bound is checkable.
  a_card_count: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle) |-> (32'(stack_n_q) + 32'(discard_n_q) + 32'(board_lib_q)
                             + 32'(board_fas_q) == N_CARDS));
  a_lib_count: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle) |-> (32'($countones(stack_q)) + 32'(board_lib_q) <= N_LIB));
  a_stack_clean: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle) |-> ((stack_q >> stack_n_q) == '0));
  a_shuf_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StShuf) |-> (lib_rem_q <= rem_q) && (rem_q != 5'd0));
  a_lfsr_live: assert property (@(posedge clk) disable iff (!rst_n) lfsr_q != 8'd0);

endmodule
